// File: rtl/i2c_master_ctrl_if.sv
// Host handshake and I2C bus/datapath signals of the I2C master control stage.
// The master modport is the controller side; the slave modport is the host/datapath/bus side.
interface i2c_master_ctrl_if;
  logic       start;
  logic       rw;
  logic       sda_in;
  logic       scl_in;
  logic       scl;
  logic [7:0] state;
  logic [3:0] count;
  logic       i2c_scl_en;
  logic       i2c_write_en;
  logic       busy;
  logic       done;
  logic       ack_error;

  modport master (
    input  start, rw, sda_in, scl_in,
    output scl, state, count, i2c_scl_en, i2c_write_en, busy, done, ack_error
  );

  modport slave (
    output start, rw, sda_in, scl_in,
    input  scl, state, count, i2c_scl_en, i2c_write_en, busy, done, ack_error
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// I2C master control stage: SCL divider, single-byte transaction FSM and host status.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_ctrl #(
  parameter int HALF_PERIOD = 4
) (
  input logic               clk,
  input logic               resetN,
  i2c_master_ctrl_if.master bus
);

  localparam logic [7:0] S_IDLE       = 8'd0;
  localparam logic [7:0] S_START      = 8'd1;
  localparam logic [7:0] S_ADDRESS    = 8'd2;
  localparam logic [7:0] S_READ_ACK   = 8'd3;
  localparam logic [7:0] S_WRITE_DATA = 8'd4;
  localparam logic [7:0] S_READ_ACK2  = 8'd5;
  localparam logic [7:0] S_READ_DATA  = 8'd6;
  localparam logic [7:0] S_WRITE_ACK2 = 8'd7;
  localparam logic [7:0] S_STOP       = 8'd8;

  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] state_q;
  logic [3:0] count_q;
  logic [7:0] div_q;
  logic       scl_q;
  logic       rw_q;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;
  logic       hold;
  logic       div_wrap;
  logic       rise_tick;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low during our high phase freezes the divider.
  assign hold = scl_q & ~bus.scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign hold          = 1'b0;
`endif

  assign div_wrap  = (state_q != S_IDLE) && !hold && (div_q == DIV_LAST);
  assign rise_tick = div_wrap && !scl_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd7;
      div_q     <= 8'd0;
      scl_q     <= 1'b1;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        div_q <= 8'd0;
        scl_q <= 1'b1;
        if (bus.start) begin
          state_q   <= S_START;
          rw_q      <= bus.rw;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
        end
      end else begin
        if (!hold) div_q <= div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) scl_q <= ~scl_q;
        // State/count only move on the SCL rise, keeping them stable at the falling edge.
        if (rise_tick) begin
          case (state_q)
            S_START: begin
              state_q <= S_ADDRESS;
              count_q <= 4'd7;
            end
            S_ADDRESS:
              if (count_q != 4'd0) count_q <= count_q - 4'd1;
              else                 state_q <= S_READ_ACK;
            S_READ_ACK:
              if (bus.sda_in) begin
                ack_err_q <= 1'b1;
                state_q   <= S_STOP;
              end else begin
                state_q <= rw_q ? S_READ_DATA : S_WRITE_DATA;
                count_q <= 4'd7;
              end
            S_WRITE_DATA:
              if (count_q != 4'd0) count_q <= count_q - 4'd1;
              else                 state_q <= S_READ_ACK2;
            S_READ_ACK2: begin
              ack_err_q <= ack_err_q | bus.sda_in;
              state_q   <= S_STOP;
            end
            S_READ_DATA:
              if (count_q != 4'd0) count_q <= count_q - 4'd1;
              else                 state_q <= S_WRITE_ACK2;
            S_WRITE_ACK2: state_q <= S_STOP;
            S_STOP: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              div_q   <= 8'd0;
              scl_q   <= 1'b1;
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.scl          = scl_q;
  assign bus.state        = state_q;
  assign bus.count        = count_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.ack_error    = ack_err_q;
  assign bus.i2c_scl_en   = (state_q != S_IDLE);
  assign bus.i2c_write_en = (state_q == S_START)      || (state_q == S_ADDRESS) ||
                            (state_q == S_WRITE_DATA) || (state_q == S_WRITE_ACK2) ||
                            (state_q == S_STOP);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: table of whole transfers plus reset/stretch corner sequences.
module tb_i2c_master_ctrl;

  typedef struct {
    logic        rw;
    logic        nack_addr;
    logic        nack_data;
    logic        pester;
    int          exp_len;
    logic [31:0] exp_seq;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic resetN;
  logic stretch_lo;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[7];

  i2c_master_ctrl_if bus();

  i2c_master_ctrl #(.HALF_PERIOD(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Open-drain SCL as seen on the bus: a stretching slave can pull it low.
  assign bus.scl_in = bus.scl & ~stretch_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit we_expected(input logic [7:0] st);
    return (st == 8'd1) || (st == 8'd2) || (st == 8'd4) || (st == 8'd7) || (st == 8'd8);
  endfunction

  function automatic bit is_data_state(input logic [7:0] st);
    return (st == 8'd2) || (st == 8'd4) || (st == 8'd6);
  endfunction

  task automatic run_xfer(input vec_t v, input bit stretch, input string tag);
    int          n;
    int          first_fall;
    int          bad_cnt;
    int          bad_we;
    int          bad_en;
    int          stretch_left;
    bit          stretched;
    bit          got_done;
    logic [31:0] seq;
    logic [7:0]  last_st;
    logic [3:0]  last_cnt;
    @(negedge clk);
    bus.rw    = v.rw;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_accept_state"}, int'(bus.state), 1);
    chk({tag, "_accept_busy"}, int'(bus.busy), 1);
    chk({tag, "_accept_ackerr_clr"}, int'(bus.ack_error), 0);
    n = 0; first_fall = -1; bad_cnt = 0; bad_we = 0; bad_en = 0;
    stretch_left = 0; stretched = 0; got_done = 0;
    seq = 32'h1; last_st = bus.state; last_cnt = bus.count;
    while (!got_done && n < 400) begin
      bus.sda_in = (bus.state == 8'd3) ? v.nack_addr :
                   (bus.state == 8'd5) ? v.nack_data : 1'b1;
      if (v.pester) bus.start = (bus.state >= 8'd2) && (bus.state <= 8'd7);
      if (stretch && !stretched && bus.state == 8'd2 && bus.count == 4'd5 && bus.scl) begin
        stretch_lo   = 1'b1;
        stretch_left = 10;
        stretched    = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) stretch_lo = 1'b0;
      end
      if (first_fall < 0 && !bus.scl) first_fall = n;
      if (bus.i2c_write_en != we_expected(bus.state)) bad_we++;
      if (bus.i2c_scl_en != (bus.state != 8'd0)) bad_en++;
      if (bus.busy != (bus.state != 8'd0)) bad_en++;
      if (bus.state != last_st) begin
        if (is_data_state(last_st) && last_cnt != 4'd0) bad_cnt++;
        if (is_data_state(bus.state) && bus.count != 4'd7) bad_cnt++;
        seq = (seq << 4) | {28'd0, bus.state[3:0]};
      end else if (is_data_state(bus.state) && bus.count != last_cnt &&
                   bus.count != 4'(last_cnt - 4'd1)) begin
        bad_cnt++;
      end
      last_st  = bus.state;
      last_cnt = bus.count;
      if (bus.done) got_done = 1'b1;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, int'(got_done), 1);
    chk({tag, "_length_clk"}, n, v.exp_len + (stretch ? 10 : 0));
    chk({tag, "_state_seq"}, int'(seq), int'(v.exp_seq));
    chk({tag, "_ack_error"}, int'(bus.ack_error), int'(v.exp_err));
    chk({tag, "_first_scl_fall"}, first_fall, 4);
    chk({tag, "_count_steps_bad"}, bad_cnt, 0);
    chk({tag, "_write_en_bad"}, bad_we, 0);
    chk({tag, "_scl_en_busy_bad"}, bad_en, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, int'(bus.done), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_count"}, int'(bus.count), 7);
    chk({tag, "_scl"}, int'(bus.scl), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_scl_en"}, int'(bus.i2c_scl_en), 0);
    chk({tag, "_write_en"}, int'(bus.i2c_write_en), 0);
  endtask

  initial begin
    int  waited;
    int  done_seen;
    n_cmp = 0; n_bad = 0;
    resetN = 1'b0; stretch_lo = 1'b0;
    bus.start = 1'b0; bus.rw = 1'b0; bus.sda_in = 1'b1;

    //         rw    nack_a nack_d pester len  seq           err
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 160, 32'h0123_4580, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 160, 32'h0123_6780, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0,  88, 32'h0001_2380, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 160, 32'h0123_4580, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 160, 32'h0123_4580, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0,  88, 32'h0001_2380, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 160, 32'h0123_6780, 1'b0};

    #23;
    check_idle_outputs("rst");
    chk("rst_ack_error", int'(bus.ack_error), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_rst");

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset in the middle of the data byte aborts without a STOP or done pulse.
    @(negedge clk);
    bus.rw = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waited = 0;
    while (!(bus.state == 8'd4 && bus.count == 4'd3) && waited < 300) begin
      bus.sda_in = (bus.state == 8'd3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    chk("abort_reached_wd3", int'(waited < 300), 1);
    #2;
    resetN = 1'b0;
    #1;
    check_idle_outputs("abort");
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.state != 8'd0) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    run_xfer(vecs[0], 1'b0, "after_abort");

`ifdef I2C_CLK_STRETCH_EN
    run_xfer(vecs[0], 1'b1, "stretch");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
